frame_buf_writer: RTL

Write-side counterpart to the pixel ROMs in the HDMI picture/filter demos. It accepts a raster pixel stream with a valid/ready handshake and start-of-frame/end-of-line markers, such as the output of the median filter. It generates the write strobe, address and data for a single-port or simple-dual-port block RAM holding one H_ACTIVE×V_ACTIVE frame, which the display path later reads back. It also checks line and frame framing, resynchronises on errors, and reports frame completion.

---
 rtl/frame_buf_writer_if.sv | 45 ++++
 rtl/frame_buf_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_writer_if.sv
// -----------------------------------------------------------------------------
// frame_buf_writer_if
//
// Bundles the two buses of the frame buffer writer:
//   - the incoming raster pixel stream (valid/ready handshake with
//     start-of-frame and end-of-line markers), and
//   - the outgoing block-RAM write port (strobe, address, data).
//
// Signals:
//   s_valid  source -> writer  beat valid
//   s_ready  writer -> source  beat ready (accept = s_valid && s_ready)
//   s_data   source -> writer  pixel, DATA_WIDTH bits
//   s_sof    source -> writer  first pixel of a frame
//   s_eol    source -> writer  last pixel of a line
//   wr_en    writer -> RAM     write strobe
//   wr_addr  writer -> RAM     write address, ADDR_WIDTH bits
//   wr_data  writer -> RAM     write data, DATA_WIDTH bits
//
// Modports:
//   slave  - the frame buffer writer itself
//   master - the pixel source / RAM side (e.g. a testbench)
// -----------------------------------------------------------------------------
interface frame_buf_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sof;
  logic                  s_eol;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport slave (
    input  s_valid, s_data, s_sof, s_eol,
    output s_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output s_valid, s_data, s_sof, s_eol,
    input  s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/frame_buf_writer.sv
// -----------------------------------------------------------------------------
// frame_buf_writer
//
// Takes a raster pixel stream and writes one H_ACTIVE x V_ACTIVE frame into a
// block RAM, pixel (row, col) landing at address row*H_ACTIVE + col. Capture
// starts at the first start-of-frame beat seen after arm is high. Line length
// is checked against the end-of-line marker. A bad line makes the writer drop
// back to hunting for the next start-of-frame. A start-of-frame in the middle
// of a frame restarts the frame at address 0. Each completed frame produces a
// frame_done pulse and bumps frame_cnt.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   arm         level; allows capture of the next frame
//   bus         stream in / RAM write out (frame_buf_writer_if.slave)
//   busy        high while hunting for SOF or writing a frame
//   frame_done  one-cycle pulse, coincident with the last pixel's write
//   err_sync    one-cycle pulse per framing error
//   frame_cnt   completed-frame counter, wraps 255 -> 0
//
// Timing: a beat accepted at edge N shows up on the RAM port in cycle N+1.
// s_ready and busy depend only on the registered state. There is no
// combinational path from s_valid to s_ready.
// -----------------------------------------------------------------------------
module frame_buf_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 256,
  parameter int V_ACTIVE   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  frame_buf_writer_if.slave  bus,
  output logic               busy,
  output logic               frame_done,
  output logic               err_sync,
  output logic [7:0]         frame_cnt
);

  // V_ACTIVE = 1 would give a zero-width row counter, so keep it at least 1 bit.
  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]      ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Registered state
  state_t                r_state;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_err_sync;
  logic [7:0]            r_frame_cnt;

  // Next-state values
  state_t                w_state_next;
  logic [COL_W-1:0]      w_col_next;
  logic [ROW_W-1:0]      w_row_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_wr_en_next;
  logic [ADDR_WIDTH-1:0] w_wr_addr_next;
  logic [DATA_WIDTH-1:0] w_wr_data_next;
  logic                  w_err_sync_next;
  logic [7:0]            w_frame_cnt_next;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_col_last;
  logic                  w_row_last;

  // Decoded from the registered state only.
  assign w_ready    = (r_state == ST_WAIT_SOF) || (r_state == ST_WRITE);
  assign w_accept   = bus.s_valid && w_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err_sync  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_addr      <= w_addr_next;
      r_wr_en     <= w_wr_en_next;
      r_wr_addr   <= w_wr_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_err_sync  <= w_err_sync_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and write-port logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_col_next       = r_col;
    w_row_next       = r_row;
    w_addr_next      = r_addr;
    w_wr_en_next     = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_err_sync_next  = 1'b0;
    w_frame_cnt_next = r_frame_cnt;

    unique case (r_state)
      ST_IDLE: begin
        w_col_next  = '0;
        w_row_next  = '0;
        w_addr_next = '0;
        if (arm) begin
          w_state_next = ST_WAIT_SOF;
        end
      end

      ST_WAIT_SOF: begin
        // Beats without SOF are swallowed so that a source already running
        // mid-frame does not stall.
        if (w_accept && bus.s_sof) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = '0;
          w_wr_data_next = bus.s_data;
          w_col_next     = COL_ONE;
          w_row_next     = '0;
          w_addr_next    = ADDR_ONE;
          w_state_next   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (w_accept) begin
          if (bus.s_sof) begin
            // The source restarted its frame, so follow it. The SOF pixel is
            // still good data, so write it rather than dropping a frame.
            w_err_sync_next = 1'b1;
            w_wr_en_next    = 1'b1;
            w_wr_addr_next  = '0;
            w_wr_data_next  = bus.s_data;
            w_col_next      = COL_ONE;
            w_row_next      = '0;
            w_addr_next     = ADDR_ONE;
          end else if (bus.s_eol != w_col_last) begin
            // Short or long line: the position of the rest of the frame can
            // no longer be trusted, so wait for the next SOF.
            w_err_sync_next = 1'b1;
            w_col_next      = '0;
            w_row_next      = '0;
            w_addr_next     = '0;
            w_state_next    = ST_WAIT_SOF;
          end else begin
            w_wr_en_next   = 1'b1;
            w_wr_addr_next = r_addr;
            w_wr_data_next = bus.s_data;
            w_addr_next    = r_addr + ADDR_ONE;
            if (w_col_last) begin
              w_col_next = '0;
              if (w_row_last) begin
                // Count the frame now so that frame_cnt already shows the new
                // value while frame_done is high.
                w_row_next       = '0;
                w_state_next     = ST_DONE;
                w_frame_cnt_next = r_frame_cnt + 8'd1;
              end else begin
                w_row_next = r_row + ROW_ONE;
              end
            end else begin
              w_col_next = r_col + COL_ONE;
            end
          end
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready = w_ready;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign busy        = w_ready;
  assign frame_done  = (r_state == ST_DONE);
  assign err_sync    = r_err_sync;
  assign frame_cnt   = r_frame_cnt;

endmodule
